// File: rtl/dma_pkg.sv
// Shared types for the DMA channel arbiter: channel index, arbiter state encoding
// and the one-hot acknowledge helper.
package dma_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] chIdx_t;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    PEND    = 4'b0010,
    GRANT   = 4'b0100,
    RELEASE = 4'b1000
  } arbState_t;

  function automatic logic [NUM_CH-1:0] onehot(input chIdx_t idx);
    logic [NUM_CH-1:0] vec;
    case (idx)
      2'd0:    vec = 4'b0001;
      2'd1:    vec = 4'b0010;
      2'd2:    vec = 4'b0100;
      2'd3:    vec = 4'b1000;
      default: vec = 4'b0000;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational channel picker: scans effective requests starting at the
// highest-priority index and wrapping round, returning the first one found.
module dma_priority_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  chIdx_t            hi_idx,
  output chIdx_t            winner,
  output logic              valid
);

  logic [2*NUM_CH-1:0] dbl_s;
  logic [NUM_CH-1:0]   rot_s;
  chIdx_t              off_s;

  // rotate so hi_idx lands in bit 0, find the first request, rotate the offset back
  always_comb begin
    dbl_s = {req, req};
    rot_s = dbl_s[{1'b0, hi_idx} +: NUM_CH];
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
    valid  = |rot_s;
    winner = hi_idx + off_s;
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel request arbiter: DREQ synchroniser, request merge and grant FSM.
// Rotating priority is built only when DMA_ARB_ROTATING_PRIORITY_EN is defined.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH     = dma_pkg::NUM_CH,
  parameter int SYNC_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreqSenseLow,
  input  logic              controllerDisable,
  input  logic              rotatingPriority,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] softwareReq,
  input  logic              assertDACK,
  input  logic              intEOP,
  output logic              channelPending,
  output chIdx_t            activeChannel,
  output logic [NUM_CH-1:0] DACK,
  output logic [NUM_CH-1:0] clearSwReq,
  output logic [NUM_CH-1:0] requestStatus
);

  logic [SYNC_DEPTH-1:0][NUM_CH-1:0] sync_r;
  logic [NUM_CH-1:0] sync_dreq_s;
  logic [NUM_CH-1:0] raw_req_s;
  logic [NUM_CH-1:0] eff_req_s;

  arbState_t         state_r;
  arbState_t         state_nxt_s;
  chIdx_t            active_r;
  chIdx_t            active_nxt_s;
  logic              pending_r;
  logic              pending_nxt_s;
  logic [NUM_CH-1:0] dack_r;
  logic [NUM_CH-1:0] dack_nxt_s;
  logic [NUM_CH-1:0] clr_r;
  logic [NUM_CH-1:0] clr_nxt_s;
  logic [NUM_CH-1:0] status_r;

  chIdx_t            hi_idx_s;
  chIdx_t            win_idx_s;
  logic              win_valid_s;

  // DREQ is asynchronous; only the last synchroniser stage is used
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_r <= '{default: {NUM_CH{1'b0}}};
    end else begin
      sync_r <= {sync_r[SYNC_DEPTH-2:0], DREQ};
    end
  end

  assign sync_dreq_s = sync_r[SYNC_DEPTH-1];
  // raw_req_s ignores controllerDisable so an in-flight service is never aborted by it
  assign raw_req_s   = ((sync_dreq_s ^ {NUM_CH{dreqSenseLow}}) | softwareReq) & ~maskReg;
  assign eff_req_s   = controllerDisable ? {NUM_CH{1'b0}} : raw_req_s;

`ifdef DMA_ARB_ROTATING_PRIORITY_EN
  chIdx_t ptr_r;

  // after serving channel n, channel n+1 becomes highest priority
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_r <= 2'd0;
    end else if ((state_r == RELEASE) && rotatingPriority) begin
      ptr_r <= active_r + 2'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign hi_idx_s = rotatingPriority ? ptr_r : 2'd0;
`else
  logic unused_rot_s;
  assign unused_rot_s = rotatingPriority;
  assign hi_idx_s     = 2'd0;
`endif

  dma_priority_encoder u_encoder (
    .req    (eff_req_s),
    .hi_idx (hi_idx_s),
    .winner (win_idx_s),
    .valid  (win_valid_s)
  );

  // next state and next registered outputs
  always_comb begin
    state_nxt_s   = state_r;
    active_nxt_s  = active_r;
    pending_nxt_s = pending_r;
    dack_nxt_s    = dack_r;
    clr_nxt_s     = {NUM_CH{1'b0}};
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          state_nxt_s   = PEND;
          active_nxt_s  = win_idx_s;
          pending_nxt_s = 1'b1;
        end else begin
          pending_nxt_s = 1'b0;
          dack_nxt_s    = {NUM_CH{1'b0}};
        end
      end
      PEND: begin
        // a withdrawn or masked request cancels the service before any grant
        if (!raw_req_s[active_r]) begin
          state_nxt_s   = IDLE;
          pending_nxt_s = 1'b0;
        end else if (assertDACK) begin
          state_nxt_s = GRANT;
          dack_nxt_s  = onehot(active_r);
        end else begin
          state_nxt_s = PEND;
        end
      end
      GRANT: begin
        if (intEOP || !assertDACK) begin
          state_nxt_s   = RELEASE;
          dack_nxt_s    = {NUM_CH{1'b0}};
          pending_nxt_s = 1'b0;
          clr_nxt_s     = onehot(active_r);
        end else begin
          state_nxt_s = GRANT;
        end
      end
      RELEASE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s   = IDLE;
        pending_nxt_s = 1'b0;
        dack_nxt_s    = {NUM_CH{1'b0}};
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r   <= IDLE;
      active_r  <= 2'd0;
      pending_r <= 1'b0;
      dack_r    <= {NUM_CH{1'b0}};
      clr_r     <= {NUM_CH{1'b0}};
      status_r  <= {NUM_CH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      active_r  <= active_nxt_s;
      pending_r <= pending_nxt_s;
      dack_r    <= dack_nxt_s;
      clr_r     <= clr_nxt_s;
      status_r  <= eff_req_s;
    end
  end

  assign channelPending = pending_r;
  assign activeChannel  = active_r;
  assign DACK           = dack_r;
  assign clearSwReq     = clr_r;
  assign requestStatus  = status_r;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Randomised scoreboard bench for dma_priority_arbiter; the winner of each service
// is predicted from the request set and a priority pointer kept by the bench.
module tb_dma_priority_arbiter;

`ifdef DMA_ARB_ROTATING_PRIORITY_EN
  localparam bit ROT_BUILD = 1'b1;
`else
  localparam bit ROT_BUILD = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic       dreqSenseLow;
  logic       controllerDisable;
  logic       rotatingPriority;
  logic [3:0] maskReg;
  logic [3:0] softwareReq;
  logic       assertDACK;
  logic       intEOP;
  logic       channelPending;
  logic [1:0] activeChannel;
  logic [3:0] DACK;
  logic [3:0] clearSwReq;
  logic [3:0] requestStatus;

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;
  logic [3:0] dack_q[$];
  logic [3:0] clr_q[$];
  logic [3:0] prev_dack = 4'b0000;

  dma_priority_arbiter dut (
    .CLK               (CLK),
    .RESET_N           (RESET_N),
    .DREQ              (DREQ),
    .dreqSenseLow      (dreqSenseLow),
    .controllerDisable (controllerDisable),
    .rotatingPriority  (rotatingPriority),
    .maskReg           (maskReg),
    .softwareReq       (softwareReq),
    .assertDACK        (assertDACK),
    .intEOP            (intEOP),
    .channelPending    (channelPending),
    .activeChannel     (activeChannel),
    .DACK              (DACK),
    .clearSwReq        (clearSwReq),
    .requestStatus     (requestStatus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // first channel with a request, searching from hi and wrapping round
  function automatic int pick(input logic [3:0] eff, input int hi);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] c;
      c = 2'((hi + i) % 4);
      if (eff[c]) return int'(c);
    end
    return -1;
  endfunction

  // monitor: every DACK rise and every clear pulse must match the next queued expectation
  always @(negedge CLK) begin
    if (DACK != 4'b0000 && prev_dack == 4'b0000) begin
      if (dack_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dack_unexpected: got %b required none", DACK);
      end else begin
        check("dack_grant", DACK, dack_q.pop_front());
      end
    end
    if (clearSwReq != 4'b0000) begin
      if (clr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL clr_unexpected: got %b required none", clearSwReq);
      end else begin
        check("clr_pulse", clearSwReq, clr_q.pop_front());
      end
    end
    prev_dack <= DACK;
  end

  task automatic load(input logic [3:0] dreq, input logic [3:0] sw, input logic [3:0] mask,
                      input bit sense, input bit rot, output int w);
    logic [3:0] eff;
    int hi;
    controllerDisable = 1'b1;
    dreqSenseLow      = sense;
    DREQ              = dreq ^ {4{sense}};
    softwareReq       = sw;
    maskReg           = mask;
    rotatingPriority  = rot;
    repeat (3) @(negedge CLK);
    check("disable_pending", {31'b0, channelPending}, 32'd0);
    check("disable_status", {28'b0, requestStatus}, 32'd0);
    controllerDisable = 1'b0;
    @(negedge CLK);
    eff = (dreq | sw) & ~mask;
    hi  = (ROT_BUILD && rot) ? ptr_m : 0;
    w   = pick(eff, hi);
    check("req_status", {28'b0, requestStatus}, {28'b0, eff});
    check("pending", {31'b0, channelPending}, {31'b0, (eff != 4'b0000)});
    if (w >= 0) check("winner", {30'b0, activeChannel}, w);
  endtask

  task automatic serve(input int w, input int k, input bit eop, input bit mask_in_grant);
    bit seen;
    logic [3:0] oh;
    oh = 4'(1 << w);
    dack_q.push_back(oh);
    clr_q.push_back(oh);
    DREQ = {4{dreqSenseLow}};
    seen = 1'b0;
    for (int t = 0; t < k + 6 && !seen; t++) begin
      assertDACK = (t < k);
      intEOP     = eop && (t == k - 1 || t == k);
      @(negedge CLK);
      if (t == 0 || (t < k && !(eop && t == k - 1))) check("dack_hold", {28'b0, DACK}, {28'b0, oh});
      if (t == 0 && mask_in_grant) maskReg[w] = 1'b1;
      if (clearSwReq != 4'b0000) seen = 1'b1;
    end
    assertDACK = 1'b0;
    intEOP     = 1'b0;
    check("release_seen", {31'b0, seen}, 32'd1);
    check("release_dack", {28'b0, DACK}, 32'd0);
    softwareReq = 4'b0000;
    if (ROT_BUILD && rotatingPriority) ptr_m = (w + 1) % 4;
    repeat (2) @(negedge CLK);
    check("idle_pending", {31'b0, channelPending}, 32'd0);
    check("idle_dack", {28'b0, DACK}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    bit dropped;
    RESET_N = 1'b0; DREQ = 4'b0110; dreqSenseLow = 1'b0; controllerDisable = 1'b0;
    rotatingPriority = 1'b0; maskReg = 4'b0000; softwareReq = 4'b0000;
    assertDACK = 1'b0; intEOP = 1'b0;

    // reset with requests present, then DREQ-to-pending latency
    repeat (3) @(negedge CLK);
    check("reset_dack", {28'b0, DACK}, 32'd0);
    check("reset_pending", {31'b0, channelPending}, 32'd0);
    check("reset_active", {30'b0, activeChannel}, 32'd0);
    check("reset_clr", {28'b0, clearSwReq}, 32'd0);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
    check("pend_not_early", {31'b0, channelPending}, 32'd0);
    @(negedge CLK);
    check("pend_latency", {31'b0, channelPending}, 32'd1);
    check("reset_winner", {30'b0, activeChannel}, 32'd1);
    serve(1, 2, 1'b1, 1'b0);

    // fixed priority, all requesting: ch0 twice
    for (int n = 0; n < 2; n++) begin
      load(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, w);
      if (w >= 0) serve(w, 3, 1'b1, 1'b0);
    end

    // rotating (or fixed in the default build), five services
    for (int n = 0; n < 5; n++) begin
      load(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, w);
      if (w >= 0) serve(w, 2, 1'b1, 1'b0);
    end

    // masked software request stays idle until unmasked
    rotatingPriority = 1'b0; DREQ = 4'b0000; dreqSenseLow = 1'b0;
    maskReg = 4'b0001; softwareReq = 4'b0001;
    repeat (4) @(negedge CLK);
    check("mask_pending", {31'b0, channelPending}, 32'd0);
    check("mask_status", {28'b0, requestStatus}, 32'd0);
    maskReg = 4'b0000;
    @(negedge CLK);
    check("unmask_pending", {31'b0, channelPending}, 32'd1);
    check("unmask_active", {30'b0, activeChannel}, 32'd0);
    serve(0, 1, 1'b0, 1'b0);

    // DREQ withdrawn while pending: back to idle without a grant
    load(4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, w);
    DREQ = 4'b0000;
    dropped = 1'b0;
    for (int t = 0; t < 6 && !dropped; t++) begin
      @(negedge CLK);
      check("drop_no_dack", {28'b0, DACK}, 32'd0);
      if (!channelPending) dropped = 1'b1;
    end
    check("drop_pending_falls", {31'b0, dropped}, 32'd1);
    repeat (2) @(negedge CLK);

    // randomised services
    for (int n = 0; n < 40; n++) begin
      logic [3:0] d, s, m;
      d = 4'($urandom);
      s = 4'($urandom & $urandom);
      m = 4'($urandom & $urandom);
      load(d, s, m, 1'($urandom), 1'($urandom), w);
      if (w >= 0) serve(w, int'($urandom_range(1, 3)), 1'($urandom), 1'($urandom));
    end

    // reset mid-GRANT clears DACK at once and the priority pointer
    load(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, w);
    if (w >= 0) serve(w, 1, 1'b1, 1'b0);
    load(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, w);
    if (w >= 0) begin
      dack_q.push_back(4'(1 << w));
      DREQ = 4'b0000;
      assertDACK = 1'b1;
      @(negedge CLK);
      check("pre_reset_dack", {28'b0, DACK}, 32'(1 << w));
      #2 RESET_N = 1'b0;
      #1;
      check("async_reset_dack", {28'b0, DACK}, 32'd0);
      check("async_reset_pending", {31'b0, channelPending}, 32'd0);
      check("async_reset_active", {30'b0, activeChannel}, 32'd0);
      assertDACK = 1'b0;
      ptr_m = 0;
      @(negedge CLK);
      RESET_N = 1'b1;
    end
    load(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, w);
    if (w >= 0) serve(w, 2, 1'b0, 1'b0);

    repeat (2) @(negedge CLK);
    check("dack_queue_drained", dack_q.size(), 32'd0);
    check("clr_queue_drained", clr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
